// File: rtl/mod_addsub_serial.sv
// Word-serial modular adder/subtractor: streams (A+B) mod P or (A-B) mod P
// one W-bit word per cycle, computing both candidate results in parallel chains.
module mod_addsub_serial #(
   parameter int W = 16,
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_a,
   input  logic         load_b,
   input  logic         load_p,
   input  logic [W-1:0] datain,
   input  logic         start,
   input  logic         mode,
   input  logic         out_rd,
   output logic         busy,
   output logic         done,
   output logic         result_flag,
   output logic [W-1:0] dataout,
   output logic         out_valid
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, SEL} state_t;

   state_t state_reg, state_next;

   logic [W-1:0] a_mem  [N];
   logic [W-1:0] b_mem  [N];
   logic [W-1:0] p_mem  [N];
   logic [W-1:0] s0_mem [N];
   logic [W-1:0] s1_mem [N];

   logic [CW-1:0] ptr_a_reg, ptr_b_reg, ptr_p_reg, k_reg, rd_ptr_reg;
   logic          cy0_reg, cy1_reg, mode_reg;
   logic          busy_reg, done_reg, flag_reg, out_valid_reg;
   logic [W-1:0]  dataout_reg;

   logic [W:0]    s0_wide, s1_wide;
   logic          sel;
   logic          idle_load;

   function automatic logic [CW-1:0] ptr_inc(input logic [CW-1:0] p);
      return (p == CW'(N - 1)) ? '0 : p + CW'(1);
   endfunction

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (k_reg == CW'(N - 1)) state_next = SEL;
         SEL:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Chain 0 forms A+/-B; chain 1 applies the -/+P correction to the same word
   // before it is stored, so both candidates finish together.
   always_comb begin
      s0_wide = '0;
      s1_wide = '0;
      if (!mode_reg) begin
         s0_wide = {1'b0, a_mem[k_reg]} + {1'b0, b_mem[k_reg]} + (W+1)'(cy0_reg);
         s1_wide = {1'b0, s0_wide[W-1:0]} - {1'b0, p_mem[k_reg]} - (W+1)'(cy1_reg);
      end else begin
         s0_wide = {1'b0, a_mem[k_reg]} - {1'b0, b_mem[k_reg]} - (W+1)'(cy0_reg);
         s1_wide = {1'b0, s0_wide[W-1:0]} + {1'b0, p_mem[k_reg]} + (W+1)'(cy1_reg);
      end
   end

   // Add: corrected result when A+B overflowed or A+B-P did not borrow.
   assign sel       = mode_reg ? cy0_reg : (cy0_reg | ~cy1_reg);
   assign idle_load = rst && (state_reg == IDLE) && !start;

   always_ff @(posedge clk) begin
      if (idle_load && load_a) a_mem[ptr_a_reg] <= datain;
      if (idle_load && load_b) b_mem[ptr_b_reg] <= datain;
      if (idle_load && load_p) p_mem[ptr_p_reg] <= datain;
      if (rst && state_reg == RUN) begin
         s0_mem[k_reg] <= s0_wide[W-1:0];
         s1_mem[k_reg] <= s1_wide[W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         ptr_a_reg     <= '0;
         ptr_b_reg     <= '0;
         ptr_p_reg     <= '0;
         k_reg         <= '0;
         rd_ptr_reg    <= '0;
         cy0_reg       <= 1'b0;
         cy1_reg       <= 1'b0;
         mode_reg      <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         flag_reg      <= 1'b0;
         out_valid_reg <= 1'b0;
         dataout_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         done_reg      <= 1'b0;
         out_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  mode_reg  <= mode;
                  ptr_a_reg <= '0;
                  ptr_b_reg <= '0;
                  ptr_p_reg <= '0;
                  k_reg     <= '0;
                  cy0_reg   <= 1'b0;
                  cy1_reg   <= 1'b0;
                  busy_reg  <= 1'b1;
               end else begin
                  if (load_a) ptr_a_reg <= ptr_inc(ptr_a_reg);
                  if (load_b) ptr_b_reg <= ptr_inc(ptr_b_reg);
                  if (load_p) ptr_p_reg <= ptr_inc(ptr_p_reg);
                  if (out_rd) begin
                     dataout_reg   <= flag_reg ? s1_mem[rd_ptr_reg] : s0_mem[rd_ptr_reg];
                     out_valid_reg <= 1'b1;
                     rd_ptr_reg    <= ptr_inc(rd_ptr_reg);
                  end
               end
            end
            RUN: begin
               cy0_reg <= s0_wide[W];
               cy1_reg <= s1_wide[W];
               k_reg   <= ptr_inc(k_reg);
            end
            SEL: begin
               flag_reg   <= sel;
               done_reg   <= 1'b1;
               busy_reg   <= 1'b0;
               rd_ptr_reg <= '0;
            end
            default: ;
         endcase
      end
   end

   assign busy        = busy_reg;
   assign done        = done_reg;
   assign result_flag = flag_reg;
   assign dataout     = dataout_reg;
   assign out_valid   = out_valid_reg;

endmodule

// File: tb/tb_mod_addsub_serial.sv
// Bench for mod_addsub_serial: directed cases plus random operands checked
// against whole-operand modular arithmetic.
module tb_mod_addsub_serial;

   localparam int W   = 16;
   localparam int N   = 2;
   localparam int OPW = W * N;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         load_a = 1'b0, load_b = 1'b0, load_p = 1'b0;
   logic [W-1:0] datain = '0;
   logic         start = 1'b0, mode = 1'b0, out_rd = 1'b0;
   logic         busy, done, result_flag, out_valid;
   logic [W-1:0] dataout;

   int n_checks = 0;
   int n_fail   = 0;

   mod_addsub_serial #(.W(W), .N(N)) dut (
      .clk(clk), .rst(rst),
      .load_a(load_a), .load_b(load_b), .load_p(load_p),
      .datain(datain), .start(start), .mode(mode), .out_rd(out_rd),
      .busy(busy), .done(done), .result_flag(result_flag),
      .dataout(dataout), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic ref_model(input logic [OPW-1:0] a, b, p, input logic m,
                            output logic [OPW-1:0] r, output logic f);
      logic [OPW:0] s;
      if (!m) begin
         s = {1'b0, a} + {1'b0, b};
         if (s >= {1'b0, p}) begin
            s = s - {1'b0, p};
            f = 1'b1;
         end else begin
            f = 1'b0;
         end
         r = s[OPW-1:0];
      end else if (a < b) begin
         r = a - b + p;
         f = 1'b1;
      end else begin
         r = a - b;
         f = 1'b0;
      end
   endtask

   // which: 0=A, 1=B, 2=P; words taken LSW first from val.
   task automatic load_op(input int which, input logic [63:0] val, input int nw);
      for (int i = 0; i < nw; i++) begin
         @(negedge clk);
         datain = val[i*W +: W];
         load_a = (which == 0);
         load_b = (which == 1);
         load_p = (which == 2);
      end
      @(negedge clk);
      load_a = 1'b0;
      load_b = 1'b0;
      load_p = 1'b0;
   endtask

   task automatic load_all(input logic [OPW-1:0] a, b, p);
      load_op(0, 64'(a), N);
      load_op(1, 64'(b), N);
      load_op(2, 64'(p), N);
   endtask

   task automatic run_op(input string name, input logic m, input logic [OPW-1:0] a, b, p,
                         input bit inject);
      logic [OPW-1:0] er;
      logic           ef;
      int             cyc;
      int             busy_cnt;
      ref_model(a, b, p, m, er, ef);
      @(negedge clk);
      start = 1'b1;
      mode  = m;
      @(negedge clk);
      start = 1'b0;
      mode  = ~m;
      if (inject) begin
         start  = 1'b1;
         load_a = 1'b1;
         out_rd = 1'b1;
         datain = W'($urandom);
      end
      cyc      = 0;
      busy_cnt = 0;
      while (!done && cyc < 20) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         cyc++;
         if (inject && cyc == 1) begin
            start  = 1'b0;
            load_a = 1'b0;
            out_rd = 1'b0;
            check({name, " rd_in_run"}, 64'(out_valid), 64'd0);
         end
      end
      check({name, " latency"}, 64'(cyc), 64'(N + 1));
      check({name, " busy_cycles"}, 64'(busy_cnt), 64'(N + 1));
      check({name, " busy_at_done"}, 64'(busy), 64'd0);
      check({name, " flag"}, 64'(result_flag), 64'(ef));
      for (int i = 0; i <= N; i++) begin
         @(negedge clk);
         if (i == 0) check({name, " done_pulse"}, 64'(done), 64'd0);
         out_rd = 1'b1;
         @(negedge clk);
         out_rd = 1'b0;
         check({name, " out_valid"}, 64'(out_valid), 64'd1);
         check({name, " word"}, 64'(dataout), 64'(er[(i % N)*W +: W]));
      end
      @(negedge clk);
      check({name, " valid_drop"}, 64'(out_valid), 64'd0);
      $display("op %s mode=%0d a=%h b=%h p=%h -> flag=%0d res=%h",
               name, m, a, b, p, ef, er);
   endtask

   initial begin
      logic [OPW-1:0] ra, rb, rp;
      logic           rm;
      logic           saw_done;

      repeat (2) @(negedge clk);
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst flag", 64'(result_flag), 64'd0);
      check("rst dataout", 64'(dataout), 64'd0);
      check("rst out_valid", 64'(out_valid), 64'd0);
      rst = 1'b1;

      load_all(32'h0000FFF0, 32'h00000005, 32'h0000FFF1);
      run_op("add_wrap", 1'b0, 32'h0000FFF0, 32'h00000005, 32'h0000FFF1, 1'b0);
      load_all(32'h00000001, 32'h00000002, 32'h0000FFF1);
      run_op("add_small", 1'b0, 32'h00000001, 32'h00000002, 32'h0000FFF1, 1'b0);
      load_all(32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFB);
      run_op("add_carry", 1'b0, 32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFB, 1'b0);
      load_all(32'h00000003, 32'h00000005, 32'h0000FFF1);
      run_op("sub_borrow", 1'b1, 32'h00000003, 32'h00000005, 32'h0000FFF1, 1'b0);
      load_all(32'h00000005, 32'h00000003, 32'h0000FFF1);
      run_op("sub_plain", 1'b1, 32'h00000005, 32'h00000003, 32'h0000FFF1, 1'b0);

      // Stray start/load/read during RUN must leave operands untouched.
      load_all(32'h12345678, 32'h0ABCDEF0, 32'h87654321);
      run_op("inject", 1'b0, 32'h12345678, 32'h0ABCDEF0, 32'h87654321, 1'b1);
      run_op("rerun", 1'b1, 32'h12345678, 32'h0ABCDEF0, 32'h87654321, 1'b0);

      // Third A word wraps onto word 0.
      load_op(0, 64'h0000_0003_0002_1111, 3);
      load_op(1, 64'h0000_0000_0000_0001, N);
      load_op(2, 64'h0000_0000_0010_0000, N);
      run_op("ptr_wrap", 1'b0, 32'h00020003, 32'h00000001, 32'h00100000, 1'b0);

      // Reset in RUN cycle 1.
      load_all(32'h00001000, 32'h00002000, 32'h00004000);
      @(negedge clk);
      start = 1'b1;
      mode  = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst busy", 64'(busy), 64'd0);
      check("midrst out_valid", 64'(out_valid), 64'd0);
      check("midrst flag", 64'(result_flag), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      saw_done = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done || busy) saw_done = 1'b1;
      end
      check("midrst no_done", 64'(saw_done), 64'd0);
      load_all(32'h00001000, 32'h00002000, 32'h00004000);
      run_op("after_rst", 1'b0, 32'h00001000, 32'h00002000, 32'h00004000, 1'b0);

      for (int t = 0; t < 24; t++) begin
         rp = OPW'({$urandom, $urandom});
         if (t % 4 == 3) rp = OPW'($urandom_range(1, 40));
         if (rp == '0) rp = OPW'(1);
         ra = OPW'({$urandom, $urandom}) % rp;
         rb = (t % 6 == 5) ? ra : OPW'({$urandom, $urandom}) % rp;
         rm = 1'($urandom);
         load_all(ra, rb, rp);
         run_op($sformatf("rnd%0d", t), rm, ra, rb, rp, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
